datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
//  32-bit bus-based datapath of the RISC CPU: register file R0-R7, HI, LO, PC, IR, MAR, MDR, Y, Z(64b) and ALU.
//  A one-hot "*_out" source select drives a shared bus; "*_enable" strobes latch the bus on the rising clock edge.
//  Control signals come from the control unit, or from a bench that steps T-states.
//  Memory is external: read data arrives on m_data_in; MAR drives the address.
// PARAMETERS
//  DATA_W  32  data/bus width; all registers DATA_W, Z is 2*DATA_W
// PORTS
//  clk                  in   1       rising-edge clock
//  clr                  in   1       asynchronous active-high reset
//  r0_out..r7_out       in   1 each  drive Rn onto bus
//  hi_out, lo_out       in   1 each  drive HI / LO onto bus
//  zhi_out, zlo_out     in   1 each  drive Z[63:32] / Z[31:0] onto bus
//  pc_out, mdr_out      in   1 each  drive PC / MDR onto bus
//  r0_enable..r7_enable in   1 each  latch bus into Rn
//  hi_enable, lo_enable in   1 each  latch bus into HI / LO
//  pc_enable            in   1       latch bus into PC
//  pc_increment         in   1       PC <= PC+1
//  mar_enable           in   1       latch bus into MAR
//  mdr_enable           in   1       load MDR (source chosen by read)
//  read                 in   1       1: MDR source is m_data_in; 0: bus
//  ir_enable            in   1       latch bus into IR
//  y_enable             in   1       latch bus into Y
//  z_enable             in   1       latch ALU result into Z
//  op_code              in   5       ALU operation select
//  m_data_in            in   32      memory read data
//  bus_data             out  32      current bus value (combinational)
//  pc_q, ir_q, mar_q    out  32 each register contents
//  mdr_q, zlo_q, zhi_q  out  32 each register contents
// BEHAVIOUR
//  - clr=1 asynchronously clears every register (R0-R7, HI, LO, PC, IR, MAR, MDR, Y, Z) to 0; all outputs read 0 except bus_data.
//  - Bus is combinational from the asserted *_out.
//    Multiple asserts resolve by fixed priority: R0>..>R7>HI>LO>ZHI>ZLO>PC>MDR.
//    No assert drives bus 0.
//  - All loads occur at posedge clk while the enable is high. Values are visible on the same-cycle bus after the edge (1-cycle latency).
//  - PC: pc_enable has priority over pc_increment; pc_increment alone adds 1 (wraps 0xFFFFFFFF->0).
//  - MDR: mdr_enable&read loads m_data_in; mdr_enable&!read loads bus.
//    A *_out may drive the bus in the same cycle without affecting MDR when read=1.
//  - ALU is combinational, with A=Y and B=bus. The result is {hi,lo}; Z <= result on z_enable.
//    Ops not listed below: result = 0.
//    00011 add: lo=A+B
//    00100 sub: lo=A-B
//    00101 and: lo=A&B
//    00110 or: lo=A|B
//    00111 ror: lo=A ror B[4:0]
//    01000 rol: lo=A rol B[4:0]
//    01001 shr: lo=A>>B[4:0] (logical)
//    01010 shra: lo=A>>>B[4:0] (arithmetic)
//    01011 shl: lo=A<<B[4:0]
//    01111 mul: {hi,lo} = signed A*B (64b)
//    10000 div: lo=A/B, hi=A%B (signed, truncate toward zero)
//    10001 neg: lo=-B (two's complement)
//    10010 not: lo=~B
//    32-bit ops set hi=0. Overflow is ignored, wrap mod 2^32.
//  - div by zero: lo=0xFFFFFFFF, hi=A.
//  - Unary neg/not use the bus only; Y is ignored.
//  - op_code may change any time; only the value at the z_enable edge matters.
//  - Register with enable low holds value; an enable and its own out may be high together (reg reloads bus).
// TESTING
//  1 clr pulse mid-run -> all *_q and registers 0 immediately, without a clock.
//  2 m_data_in=0x22, read+mdr_enable; then mdr_out+r5_enable -> r5_out shows bus_data=0x00000022.
//    Same with 0x24 into R0.
//  3 NEG, with R0=0x24:
//    - pc_out+mar_enable+pc_increment -> mar_q=0, pc_q=1
//    - read+mdr_enable with m_data_in=0x88028000, then mdr_out+ir_enable -> ir_q=0x88028000
//    - r0_out+op_code=10001+z_enable -> zlo_q=0xFFFFFFDC, zhi_q=0
//    - zlo_out+r5_enable -> R5=0xFFFFFFDC
//  4 Y=7, bus=-2 (R1=0xFFFFFFFE), mul -> zhi=0xFFFFFFFF, zlo=0xFFFFFFF2.
//    div with Y=7, R1=2 -> zlo=3, zhi=1.
//    div with R1=0 -> zlo=0xFFFFFFFF, zhi=7.
//  5 Y=0x80000001, B=1: ror -> 0xC0000000; shra -> 0xC0000000; shr -> 0x40000000; add with Y=0xFFFFFFFF, B=1 -> 0.
//  6 r0_out and r5_out together -> bus_data=R0; no *_out -> bus_data=0; pc_enable+pc_increment -> PC=bus.

Source files
------------

// File: rtl/datapath.sv
// Bus-based 32-bit CPU datapath: register file, special registers, one-hot bus
// source select with fixed priority, and the combinational ALU feeding Z.
module datapath #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              r0_out,
    input  logic              r1_out,
    input  logic              r2_out,
    input  logic              r3_out,
    input  logic              r4_out,
    input  logic              r5_out,
    input  logic              r6_out,
    input  logic              r7_out,
    input  logic              hi_out,
    input  logic              lo_out,
    input  logic              zhi_out,
    input  logic              zlo_out,
    input  logic              pc_out,
    input  logic              mdr_out,
    input  logic              r0_enable,
    input  logic              r1_enable,
    input  logic              r2_enable,
    input  logic              r3_enable,
    input  logic              r4_enable,
    input  logic              r5_enable,
    input  logic              r6_enable,
    input  logic              r7_enable,
    input  logic              hi_enable,
    input  logic              lo_enable,
    input  logic              pc_enable,
    input  logic              pc_increment,
    input  logic              mar_enable,
    input  logic              mdr_enable,
    input  logic              read,
    input  logic              ir_enable,
    input  logic              y_enable,
    input  logic              z_enable,
    input  logic [4:0]        op_code,
    input  logic [DATA_W-1:0] m_data_in,
    output logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] pc_q,
    output logic [DATA_W-1:0] ir_q,
    output logic [DATA_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic [DATA_W-1:0] zlo_q,
    output logic [DATA_W-1:0] zhi_q
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [DATA_W-1:0]   gpr_r [0:7];
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic [DATA_W-1:0]   pc_r;
    logic [DATA_W-1:0]   ir_r;
    logic [DATA_W-1:0]   mar_r;
    logic [DATA_W-1:0]   mdr_r;
    logic [DATA_W-1:0]   y_r;
    logic [2*DATA_W-1:0] z_r;

    logic [7:0]          gpr_enable_s;
    logic [DATA_W-1:0]   bus_s;
    logic [DATA_W-1:0]   alu_hi_s;
    logic [DATA_W-1:0]   alu_lo_s;

    logic [SH_W-1:0]     shamt_s;
    logic [2*DATA_W-1:0] ror_wide_s;
    logic [2*DATA_W-1:0] rol_wide_s;
    logic [2*DATA_W-1:0] shra_wide_s;
    logic [2*DATA_W-1:0] prod_s;

    logic                a_neg_s;
    logic                b_neg_s;
    logic [DATA_W-1:0]   a_mag_s;
    logic [DATA_W-1:0]   b_mag_s;
    logic [DATA_W-1:0]   divisor_s;
    logic [DATA_W-1:0]   quot_mag_s;
    logic [DATA_W-1:0]   rem_mag_s;
    logic [DATA_W-1:0]   quot_s;
    logic [DATA_W-1:0]   rem_s;
    logic                div_zero_s;

    assign gpr_enable_s = {r7_enable, r6_enable, r5_enable, r4_enable,
                           r3_enable, r2_enable, r1_enable, r0_enable};

    // Shared bus source select, fixed priority R0 first down to MDR last.
    always_comb begin
        bus_s = ZERO;
        if (r0_out) begin
            bus_s = gpr_r[0];
        end else if (r1_out) begin
            bus_s = gpr_r[1];
        end else if (r2_out) begin
            bus_s = gpr_r[2];
        end else if (r3_out) begin
            bus_s = gpr_r[3];
        end else if (r4_out) begin
            bus_s = gpr_r[4];
        end else if (r5_out) begin
            bus_s = gpr_r[5];
        end else if (r6_out) begin
            bus_s = gpr_r[6];
        end else if (r7_out) begin
            bus_s = gpr_r[7];
        end else if (hi_out) begin
            bus_s = hi_r;
        end else if (lo_out) begin
            bus_s = lo_r;
        end else if (zhi_out) begin
            bus_s = z_r[2*DATA_W-1:DATA_W];
        end else if (zlo_out) begin
            bus_s = z_r[DATA_W-1:0];
        end else if (pc_out) begin
            bus_s = pc_r;
        end else if (mdr_out) begin
            bus_s = mdr_r;
        end else begin
            bus_s = ZERO;
        end
    end

    // Rotates are taken from a doubled operand so a zero amount needs no special case.
    assign shamt_s     = bus_s[SH_W-1:0];
    assign ror_wide_s  = {y_r, y_r} >> shamt_s;
    assign rol_wide_s  = {y_r, y_r} << shamt_s;
    assign shra_wide_s = {{DATA_W{y_r[DATA_W-1]}}, y_r} >> shamt_s;
    assign prod_s      = {{DATA_W{y_r[DATA_W-1]}}, y_r} * {{DATA_W{bus_s[DATA_W-1]}}, bus_s};

    // Signed divide on magnitudes; remainder takes the dividend's sign.
    assign a_neg_s    = y_r[DATA_W-1];
    assign b_neg_s    = bus_s[DATA_W-1];
    assign a_mag_s    = a_neg_s ? -y_r : y_r;
    assign b_mag_s    = b_neg_s ? -bus_s : bus_s;
    assign div_zero_s = (bus_s == ZERO);
    assign divisor_s  = div_zero_s ? ONE : b_mag_s;
    assign quot_mag_s = a_mag_s / divisor_s;
    assign rem_mag_s  = a_mag_s % divisor_s;
    assign quot_s     = (a_neg_s ^ b_neg_s) ? -quot_mag_s : quot_mag_s;
    assign rem_s      = a_neg_s ? -rem_mag_s : rem_mag_s;

    // ALU result select; A is Y, B is the bus.
    always_comb begin
        alu_hi_s = ZERO;
        alu_lo_s = ZERO;
        case (op_code)
            OP_ADD:  alu_lo_s = y_r + bus_s;
            OP_SUB:  alu_lo_s = y_r - bus_s;
            OP_AND:  alu_lo_s = y_r & bus_s;
            OP_OR:   alu_lo_s = y_r | bus_s;
            OP_ROR:  alu_lo_s = ror_wide_s[DATA_W-1:0];
            OP_ROL:  alu_lo_s = rol_wide_s[2*DATA_W-1:DATA_W];
            OP_SHR:  alu_lo_s = y_r >> shamt_s;
            OP_SHRA: alu_lo_s = shra_wide_s[DATA_W-1:0];
            OP_SHL:  alu_lo_s = y_r << shamt_s;
            OP_MUL: begin
                alu_hi_s = prod_s[2*DATA_W-1:DATA_W];
                alu_lo_s = prod_s[DATA_W-1:0];
            end
            OP_DIV: begin
                if (div_zero_s) begin
                    alu_hi_s = y_r;
                    alu_lo_s = ONES;
                end else begin
                    alu_hi_s = rem_s;
                    alu_lo_s = quot_s;
                end
            end
            OP_NEG:  alu_lo_s = -bus_s;
            OP_NOT:  alu_lo_s = ~bus_s;
            default: begin
                alu_hi_s = ZERO;
                alu_lo_s = ZERO;
            end
        endcase
    end

    // General-purpose register file R0-R7.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                gpr_r[i] <= ZERO;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (gpr_enable_s[i]) begin
                    gpr_r[i] <= bus_s;
                end else begin
                    gpr_r[i] <= gpr_r[i];
                end
            end
        end
    end

    // Special registers; PC load wins over increment, MDR source follows read.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hi_r  <= ZERO;
            lo_r  <= ZERO;
            pc_r  <= ZERO;
            ir_r  <= ZERO;
            mar_r <= ZERO;
            mdr_r <= ZERO;
            y_r   <= ZERO;
            z_r   <= {ZERO, ZERO};
        end else begin
            if (hi_enable) hi_r <= bus_s;
            else           hi_r <= hi_r;
            if (lo_enable) lo_r <= bus_s;
            else           lo_r <= lo_r;
            if (pc_enable)         pc_r <= bus_s;
            else if (pc_increment) pc_r <= pc_r + ONE;
            else                   pc_r <= pc_r;
            if (ir_enable)  ir_r <= bus_s;
            else            ir_r <= ir_r;
            if (mar_enable) mar_r <= bus_s;
            else            mar_r <= mar_r;
            if (mdr_enable) mdr_r <= read ? m_data_in : bus_s;
            else            mdr_r <= mdr_r;
            if (y_enable)   y_r <= bus_s;
            else            y_r <= y_r;
            if (z_enable)   z_r <= {alu_hi_s, alu_lo_s};
            else            z_r <= z_r;
        end
    end

    assign bus_data = bus_s;
    assign pc_q     = pc_r;
    assign ir_q     = ir_r;
    assign mar_q    = mar_r;
    assign mdr_q    = mdr_r;
    assign zlo_q    = z_r[DATA_W-1:0];
    assign zhi_q    = z_r[2*DATA_W-1:DATA_W];

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: a register-level model checked every cycle,
// plus hand-computed expectations for the key micro-operation sequences.
module tb_datapath;

    logic        clk;
    logic        clr;
    logic [7:0]  r_out;
    logic [7:0]  r_en;
    logic        hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out;
    logic        hi_en, lo_en, pc_en, pc_inc, mar_en, mdr_en, rd, ir_en, y_en, z_en;
    logic [4:0]  op_code;
    logic [31:0] m_data_in;
    logic [31:0] bus_data, pc_q, ir_q, mar_q, mdr_q, zlo_q, zhi_q;

    int checks;
    int failures;

    datapath #(.DATA_W(32)) dut (
        .clk(clk), .clr(clr),
        .r0_out(r_out[0]), .r1_out(r_out[1]), .r2_out(r_out[2]), .r3_out(r_out[3]),
        .r4_out(r_out[4]), .r5_out(r_out[5]), .r6_out(r_out[6]), .r7_out(r_out[7]),
        .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .pc_out(pc_out), .mdr_out(mdr_out),
        .r0_enable(r_en[0]), .r1_enable(r_en[1]), .r2_enable(r_en[2]), .r3_enable(r_en[3]),
        .r4_enable(r_en[4]), .r5_enable(r_en[5]), .r6_enable(r_en[6]), .r7_enable(r_en[7]),
        .hi_enable(hi_en), .lo_enable(lo_en), .pc_enable(pc_en), .pc_increment(pc_inc),
        .mar_enable(mar_en), .mdr_enable(mdr_en), .read(rd), .ir_enable(ir_en),
        .y_enable(y_en), .z_enable(z_en), .op_code(op_code), .m_data_in(m_data_in),
        .bus_data(bus_data), .pc_q(pc_q), .ir_q(ir_q), .mar_q(mar_q),
        .mdr_q(mdr_q), .zlo_q(zlo_q), .zhi_q(zhi_q)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_r [0:7];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y;
    logic [63:0] m_z;
    logic [31:0] m_b;
    logic [63:0] m_res;

    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 8; i++) begin
            if (r_out[i]) return m_r[i];
        end
        if (hi_out)  return m_hi;
        if (lo_out)  return m_lo;
        if (zhi_out) return m_z[63:32];
        if (zlo_out) return m_z[31:0];
        if (pc_out)  return m_pc;
        if (mdr_out) return m_mdr;
        return 32'd0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sa;
        longint p;
        longint q;
        longint r;
        sh = int'(b[4:0]);
        sa = a;
        case (op)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a & b};
            5'd6:  return {32'd0, a | b};
            5'd7:  return {32'd0, (a >> sh) | (a << ((32 - sh) % 32))};
            5'd8:  return {32'd0, (a << sh) | (a >> ((32 - sh) % 32))};
            5'd9:  return {32'd0, a >> sh};
            5'd10: begin
                sa = sa >>> sh;
                return {32'd0, sa};
            end
            5'd11: return {32'd0, a << sh};
            5'd15: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            5'd16: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                return {r[31:0], q[31:0]};
            end
            5'd17: return {32'd0, 32'd0 - b};
            5'd18: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    // Model register update on each active edge, mirroring the architectural rules
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) m_r[i] = 32'd0;
            m_hi = 32'd0; m_lo = 32'd0; m_pc = 32'd0; m_ir = 32'd0;
            m_mar = 32'd0; m_mdr = 32'd0; m_y = 32'd0; m_z = 64'd0;
        end else begin
            m_b   = model_bus();
            m_res = model_alu(op_code, m_y, m_b);
            for (int i = 0; i < 8; i++) if (r_en[i]) m_r[i] = m_b;
            if (hi_en)  m_hi = m_b;
            if (lo_en)  m_lo = m_b;
            if (pc_en)       m_pc = m_b;
            else if (pc_inc) m_pc = m_pc + 32'd1;
            if (mar_en) m_mar = m_b;
            if (mdr_en) m_mdr = rd ? m_data_in : m_b;
            if (ir_en)  m_ir = m_b;
            if (y_en)   m_y = m_b;
            if (z_en)   m_z = m_res;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every visible output against the model
    always @(negedge clk) begin
        if (!clr) begin
            chk("model_pc", pc_q, m_pc);
            chk("model_ir", ir_q, m_ir);
            chk("model_mar", mar_q, m_mar);
            chk("model_mdr", mdr_q, m_mdr);
            chk("model_zlo", zlo_q, m_z[31:0]);
            chk("model_zhi", zhi_q, m_z[63:32]);
            chk("model_bus", bus_data, model_bus());
        end
    end

    task automatic idle();
        r_out = 8'd0; r_en = 8'd0;
        hi_out = 1'b0; lo_out = 1'b0; zhi_out = 1'b0; zlo_out = 1'b0;
        pc_out = 1'b0; mdr_out = 1'b0;
        hi_en = 1'b0; lo_en = 1'b0; pc_en = 1'b0; pc_inc = 1'b0; mar_en = 1'b0;
        mdr_en = 1'b0; rd = 1'b0; ir_en = 1'b0; y_en = 1'b0; z_en = 1'b0;
        op_code = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        m_data_in = v; rd = 1'b1; mdr_en = 1'b1;
        tick();
    endtask

    task automatic load_r(input int idx, input logic [31:0] v);
        mem_to_mdr(v);
        mdr_out = 1'b1; r_en[idx] = 1'b1;
        tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        mem_to_mdr(v);
        mdr_out = 1'b1; y_en = 1'b1;
        tick();
    endtask

    task automatic alu_r(input int idx, input logic [4:0] op);
        r_out[idx] = 1'b1; op_code = op; z_en = 1'b1;
        tick();
    endtask

    task automatic peek_r(input string name, input int idx, input logic [31:0] exp);
        r_out[idx] = 1'b1;
        #1;
        chk(name, bus_data, exp);
        r_out[idx] = 1'b0;
    endtask

    initial begin
        logic [4:0] sweep_ops [0:8];
        sweep_ops = '{5'd4, 5'd5, 5'd6, 5'd8, 5'd11, 5'd17, 5'd18, 5'd0, 5'd31};
        checks = 0; failures = 0;
        clk = 1'b0; clr = 1'b1; m_data_in = 32'd0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc", pc_q, 32'd0);
        chk("rst_ir", ir_q, 32'd0);
        chk("rst_mar", mar_q, 32'd0);
        chk("rst_mdr", mdr_q, 32'd0);
        chk("rst_zlo", zlo_q, 32'd0);
        chk("rst_zhi", zhi_q, 32'd0);
        chk("rst_bus", bus_data, 32'd0);
        clr = 1'b0;

        // Memory loads through MDR into R5 and R0
        load_r(5, 32'h0000_0022);
        peek_r("r5_load", 5, 32'h0000_0022);
        load_r(0, 32'h0000_0024);
        peek_r("r0_load", 0, 32'h0000_0024);

        // NEG instruction sequence
        pc_out = 1'b1; mar_en = 1'b1; pc_inc = 1'b1;
        tick();
        chk("t0_mar", mar_q, 32'd0);
        chk("t0_pc", pc_q, 32'd1);
        mem_to_mdr(32'h8802_8000);
        mdr_out = 1'b1; ir_en = 1'b1;
        tick();
        chk("t2_ir", ir_q, 32'h8802_8000);
        alu_r(0, 5'b10001);
        chk("neg_zlo", zlo_q, 32'hFFFF_FFDC);
        chk("neg_zhi", zhi_q, 32'd0);
        zlo_out = 1'b1; r_en[5] = 1'b1;
        tick();
        peek_r("neg_r5", 5, 32'hFFFF_FFDC);

        // Multiply and divide
        load_r(1, 32'hFFFF_FFFE);
        load_y(32'd7);
        alu_r(1, 5'b01111);
        chk("mul_zhi", zhi_q, 32'hFFFF_FFFF);
        chk("mul_zlo", zlo_q, 32'hFFFF_FFF2);
        zhi_out = 1'b1; hi_en = 1'b1;
        tick();
        hi_out = 1'b1;
        #1;
        chk("hi_reg", bus_data, 32'hFFFF_FFFF);
        idle();
        load_r(1, 32'd2);
        alu_r(1, 5'b10000);
        chk("div_zlo", zlo_q, 32'd3);
        chk("div_zhi", zhi_q, 32'd1);
        load_r(1, 32'd0);
        alu_r(1, 5'b10000);
        chk("div0_zlo", zlo_q, 32'hFFFF_FFFF);
        chk("div0_zhi", zhi_q, 32'd7);
        load_r(1, 32'hFFFF_FFF9);
        alu_r(1, 5'b10000);
        chk("divneg_zlo", zlo_q, 32'hFFFF_FFFF);
        chk("divneg_zhi", zhi_q, 32'd0);

        // Shifts and rotates
        load_y(32'h8000_0001);
        load_r(1, 32'd1);
        alu_r(1, 5'b00111);
        chk("ror", zlo_q, 32'hC000_0000);
        alu_r(1, 5'b01010);
        chk("shra", zlo_q, 32'hC000_0000);
        alu_r(1, 5'b01001);
        chk("shr", zlo_q, 32'h4000_0000);
        alu_r(1, 5'b01000);
        chk("rol", zlo_q, 32'h0000_0003);
        alu_r(1, 5'b01011);
        chk("shl", zlo_q, 32'h0000_0002);
        load_r(2, 32'h1234_5685);
        for (int k = 0; k < 9; k++) alu_r(2, sweep_ops[k]);
        load_y(32'hFFFF_FFFF);
        alu_r(1, 5'b00011);
        chk("add_wrap", zlo_q, 32'd0);
        chk("add_zhi", zhi_q, 32'd0);

        // Bus priority, PC load priority and wrap, MDR source selection
        r_out[0] = 1'b1; r_out[5] = 1'b1;
        #1;
        chk("bus_prio", bus_data, 32'h0000_0024);
        idle();
        #1;
        chk("bus_none", bus_data, 32'd0);
        r_out[0] = 1'b1; pc_en = 1'b1; pc_inc = 1'b1;
        tick();
        chk("pc_load_prio", pc_q, 32'h0000_0024);
        mem_to_mdr(32'hFFFF_FFFF);
        mdr_out = 1'b1; pc_en = 1'b1;
        tick();
        pc_inc = 1'b1;
        tick();
        chk("pc_wrap", pc_q, 32'd0);
        m_data_in = 32'h0000_5A5A; rd = 1'b1; mdr_en = 1'b1; r_out[0] = 1'b1;
        tick();
        chk("mdr_read", mdr_q, 32'h0000_5A5A);
        r_out[5] = 1'b1; mdr_en = 1'b1;
        tick();
        chk("mdr_bus", mdr_q, 32'hFFFF_FFDC);
        r_out[5] = 1'b1; r_en[5] = 1'b1;
        tick();
        peek_r("self_reload", 5, 32'hFFFF_FFDC);

        // Asynchronous clear between edges
        clr = 1'b1;
        #1;
        chk("clr_pc", pc_q, 32'd0);
        chk("clr_ir", ir_q, 32'd0);
        chk("clr_mdr", mdr_q, 32'd0);
        chk("clr_zlo", zlo_q, 32'd0);
        chk("clr_zhi", zhi_q, 32'd0);
        r_out[5] = 1'b1;
        #0.5;
        chk("clr_r5", bus_data, 32'd0);
        #0.5;
        clr = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
